pipelined_addsub: RTL and testbench

Parametrised, pipelined adder/subtractor; the next-generation replacement for the combinational 32-bit ripple adder in the ALU/branch-target datapath. Splits a WIDTH-bit add/sub into STAGES equal slices, one slice per clock, with the carry registered between slices. Adds subtract and carry-in modes, signed-overflow and zero flags, and a valid/ready handshake on both sides. Back-pressure stalls the whole pipeline.

---
 rtl/pipelined_addsub_if.sv | 26 ++
 rtl/pipelined_addsub.sv | 75 +++++++
 tb/tb_pipelined_addsub.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for the pipelined adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             use_cin;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    modport master (
        output in_valid, a, b, sub, use_cin, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, sub, use_cin, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/sub split into STAGES carry-registered slices with valid/ready flow control.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int S = WIDTH / STAGES;
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // operands shrink by one slice per stage; finished sum bits grow by one
        localparam int W = WIDTH - k * S;
        logic [W-1:0]       a_d, b_d;
        logic [(k+1)*S-1:0] s_d, s_q;
        logic [S:0]         r;
        logic               v_d, c_d, z_d, v_q, c_q, z_q;
        if (k == 0) begin : g_in
            assign a_d = bus.a;
            assign b_d = bus.sub ? ~bus.b : bus.b;
            assign c_d = bus.sub || (bus.use_cin && bus.cin);
            assign v_d = bus.in_valid;
            assign z_d = 1'b1;
            assign s_d = r[S-1:0];
        end else begin : g_in
            assign a_d = g_stage[k-1].g_ops.a_q;
            assign b_d = g_stage[k-1].g_ops.b_q;
            assign c_d = g_stage[k-1].c_q;
            assign v_d = g_stage[k-1].v_q;
            assign z_d = g_stage[k-1].z_q;
            assign s_d = {r[S-1:0], g_stage[k-1].s_q};
        end
        assign r = {1'b0, a_d[S-1:0]} + {1'b0, b_d[S-1:0]} + {{S{1'b0}}, c_d};
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                z_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= r[S];
                z_q <= z_d && (r[S-1:0] == '0);
                s_q <= s_d;
            end
        end
        if (k < STAGES - 1) begin : g_ops
            logic [W-S-1:0] a_q, b_q;
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d[W-1:S];
                    b_q <= b_d[W-1:S];
                end
            end
        end else begin : g_last
            // carry into the MSB is recovered as a ^ b ^ sum at that bit
            logic o_q;
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) o_q <= 1'b0;
                else if (adv) o_q <= a_d[S-1] ^ b_d[S-1] ^ r[S-1] ^ r[S];
            end
        end
    end
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.carry_out = g_stage[STAGES-1].c_q;
    assign bus.zero      = g_stage[STAGES-1].z_q;
    assign bus.overflow  = g_stage[STAGES-1].g_last.o_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors, stall/stream, async reset and parameter sweep for pipelined_addsub.
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst_n;
    bit   sweep_go = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_if #(.WIDTH(32)) m ();
    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (.clock(clk), .rst_n(rst_n), .bus(m));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic uc, input logic ci, input int w);
        logic [63:0] mk, bb, t, sm;
        logic c, o, z;
        mk = (64'd1 << w) - 64'd1;
        bb = (s ? ~64'(b) : 64'(b)) & mk;
        t  = 64'(a) + bb + 64'(s | (uc & ci));
        sm = t & mk;
        c  = t[w];
        o  = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
        z  = (sm == 64'd0);
        return {29'b0, c, o, z, sm[31:0]};
    endfunction

    function automatic logic [63:0] outs();
        return {29'b0, m.carry_out, m.overflow, m.zero, m.sum};
    endfunction

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic uc, input logic ci, input logic [31:0] es, input logic [2:0] ef);
        int acc, n;
        @(negedge clk);
        m.a = a; m.b = b; m.sub = s; m.use_cin = uc; m.cin = ci; m.in_valid = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        m.in_valid = 1'b0;
        n = 0;
        while (!m.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(cyc - acc), 64'd3);
        check({tag, "_sum"}, 64'(m.sum), 64'(es));
        check({tag, "_flags"}, 64'({m.carry_out, m.overflow, m.zero}), 64'(ef));
    endtask

    logic [31:0] st_a [8] = '{32'h1234_5678, 32'hFFFF_0000, 32'h8000_0000, 32'h0000_00FF,
                              32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0000_0010, 32'hAAAA_5555};
    logic [31:0] st_b [8] = '{32'h1111_1111, 32'h0001_0000, 32'h8000_0000, 32'h0000_00FF,
                              32'h0BAD_F00D, 32'hFFFF_FFFF, 32'h0000_0020, 32'h5555_AAAA};
    logic [7:0]  st_s = 8'b1010_0110;

    initial begin
        logic [63:0] sq[$];
        logic [63:0] snap;
        int idx, got, stale, n;
        rst_n = 1'b0;
        m.in_valid = 1'b0; m.a = '0; m.b = '0; m.sub = 1'b0; m.use_cin = 1'b0; m.cin = 1'b0;
        m.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(m.out_valid), 64'd0);
        check("rst_outs", outs(), 64'd0);
        check("rst_in_ready", 64'(m.in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(m.out_valid), 64'd0);

        op("add_1_2",    32'h1,         32'h2, 0, 0, 0, 32'h3,         3'b000);
        op("ripple",     32'hFFFF_FFFF, 32'h1, 0, 0, 0, 32'h0,         3'b101);
        op("ripple_cin", 32'hFFFF_FFFF, 32'h1, 0, 1, 1, 32'h1,         3'b100);
        op("sub_5_7",    32'h5,         32'h7, 1, 0, 0, 32'hFFFF_FFFE, 3'b000);
        op("sub_ovf",    32'h8000_0000, 32'h1, 1, 0, 0, 32'h7FFF_FFFF, 3'b110);
        op("add_ovf",    32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h8000_0000, 3'b010);
        op("sub_zero",   32'h5,         32'h5, 1, 0, 0, 32'h0,         3'b101);
        op("sub_cin_ig", 32'h7,         32'h2, 1, 1, 0, 32'h5,         3'b100);
        op("add_noucin", 32'h1,         32'h2, 0, 0, 1, 32'h3,         3'b000);

        // stream of 8 beats with out_ready low for cycles 6..8
        idx = 0; got = 0; snap = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            m.out_ready = !(c >= 6 && c <= 8);
            #1;
            if (!m.out_ready) begin
                check("stall_in_ready", 64'(m.in_ready), 64'd0);
                if (c == 6) snap = outs();
                else check("stall_hold", outs(), snap);
            end
            if (m.out_valid && m.out_ready) begin
                if (sq.size() == 0) check("stream_extra", 64'd1, 64'd0);
                else check($sformatf("stream%0d", got), outs(), sq.pop_front());
                got++;
            end
            if (m.in_ready && idx < 8) begin
                m.a = st_a[idx]; m.b = st_b[idx]; m.sub = st_s[idx]; m.use_cin = 1'b0; m.cin = 1'b0;
                m.in_valid = 1'b1;
                sq.push_back(model(st_a[idx], st_b[idx], st_s[idx], 1'b0, 1'b0, 32));
                idx++;
            end else begin
                m.in_valid = 1'b0;
            end
        end
        check("stream_count", 64'(got), 64'd8);
        @(negedge clk);
        check("stream_drain", 64'(m.out_valid), 64'd0);

        // three beats stalled in flight, then asynchronous reset between edges
        m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m.a = 32'(16 * (i + 1)); m.b = 32'h1; m.sub = 1'b0; m.in_valid = 1'b1;
        end
        @(negedge clk);
        m.in_valid = 1'b0;
        n = 0;
        while (!m.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_pre_valid", 64'(m.out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(m.out_valid), 64'd0);
        check("rst_async_outs", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m.out_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (m.out_valid) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);

        sweep_go = 1'b1;
        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_done", 64'({g_sw[0].done, g_sw[1].done, g_sw[2].done, g_sw[3].done}), 64'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W  = (g == 3) ? 16 : 32;
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;
        pipelined_addsub_if #(.WIDTH(W)) sb ();
        pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u_sw (.clock(clk), .rst_n(rst_n), .bus(sb));
        logic [63:0] exp_q[$];
        int acc_q[$];
        int got = 0;
        bit done = 1'b0;
        initial begin
            sb.in_valid = 1'b0; sb.a = '0; sb.b = '0; sb.sub = 1'b0; sb.use_cin = 1'b0; sb.cin = 1'b0;
            sb.out_ready = 1'b1;
            wait (sweep_go);
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                sb.a = W'($urandom); sb.b = W'($urandom);
                sb.sub = 1'($urandom); sb.use_cin = 1'($urandom); sb.cin = 1'($urandom);
                sb.in_valid = 1'b1;
                exp_q.push_back(model(32'(sb.a), 32'(sb.b), sb.sub, sb.use_cin, sb.cin, W));
                acc_q.push_back(cyc + 1);
            end
            @(negedge clk);
            sb.in_valid = 1'b0;
            repeat (ST + 4) @(negedge clk);
            check($sformatf("sw%0d_count", g), 64'(got), 64'd1000);
            done = 1'b1;
        end
        always @(negedge clk) begin
            if (sb.out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("sw%0d_spurious", g), 64'd1, 64'd0);
                end else begin
                    check($sformatf("sw%0d_res", g),
                          {29'b0, sb.carry_out, sb.overflow, sb.zero, 32'(sb.sum)}, exp_q.pop_front());
                    check($sformatf("sw%0d_lat", g), 64'(cyc - acc_q.pop_front()), 64'(ST - 1));
                    got++;
                end
            end
        end
    end
endmodule
